// File: rtl/turf_cout_framer.sv
// Command-out framer: builds per-lane OSERDES words for NUM_SURF SURF lanes plus
// the TURFIO lane, serialising each captured frame word MSB-first over FRAME_BEATS beats.
module turf_cout_framer #(
  parameter int NUM_SURF    = 7,
  parameter int WORD_BITS   = 4,
  parameter int FRAME_BEATS = 8,
  parameter logic [WORD_BITS*FRAME_BEATS-1:0] TRAIN_PATTERN = 32'hA55A6996,
  parameter logic [WORD_BITS*FRAME_BEATS-1:0] IDLE_WORD     = 32'h00000000
) (
  input  logic                                   sysclk_i,
  input  logic                                   rst_i,
  input  logic                                   train_i,
  input  logic                                   sync_i,
  input  logic [WORD_BITS*FRAME_BEATS-1:0]          response_i,
  input  logic [NUM_SURF*WORD_BITS*FRAME_BEATS-1:0] surf_response_i,
  input  logic                                   resp_valid_i,
  output logic                                   resp_ready_o,
  input  logic [NUM_SURF:0]                      lane_enable_i,
  output logic [(NUM_SURF+1)*WORD_BITS-1:0]      lane_data_o,
  output logic                                   frame_start_o,
  output logic                                   in_train_o
);

  localparam int LANES      = NUM_SURF + 1;
  localparam int FRAME_BITS = WORD_BITS * FRAME_BEATS;
  localparam int CNT_W      = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_BEATS - 1);

  logic [CNT_W-1:0]                  beat_cnt_q, beat_cnt_d;
  logic [LANES-1:0][FRAME_BITS-1:0]  shift_q, shift_d;
  logic [LANES*WORD_BITS-1:0]        lane_data_q, lane_data_d;
  logic                              frame_start_q, frame_start_d;
  logic                              in_train_q, in_train_d;
  logic [LANES-1:0][FRAME_BITS-1:0]  frame_word;
  logic                              fs;

  // fs is the single cycle in which a whole new frame is captured.
  assign fs           = (beat_cnt_q == '0) && !rst_i;
  assign resp_ready_o = fs && !train_i && resp_valid_i;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [FRAME_BITS-1:0] lane_in;
    if (j < NUM_SURF) begin : g_surf
      assign lane_in = surf_response_i[j*FRAME_BITS +: FRAME_BITS];
    end else begin : g_tio
      assign lane_in = response_i;
    end
    assign frame_word[j] = train_i                           ? TRAIN_PATTERN :
                           (resp_valid_i && lane_enable_i[j]) ? lane_in       :
                                                                IDLE_WORD;
  end

  always_comb begin
    beat_cnt_d    = '0;
    shift_d       = '0;
    lane_data_d   = '0;
    frame_start_d = fs;
    in_train_d    = fs ? train_i : in_train_q;

    if (!sync_i && (beat_cnt_q != LAST_BEAT)) begin
      beat_cnt_d = beat_cnt_q + CNT_W'(1);
    end

    // Beat 0 goes straight out on load; the rest follow from the shifter.
    for (int j = 0; j < LANES; j++) begin
      if (fs) begin
        lane_data_d[j*WORD_BITS +: WORD_BITS] = frame_word[j][FRAME_BITS-1 -: WORD_BITS];
        shift_d[j] = frame_word[j] << WORD_BITS;
      end else begin
        lane_data_d[j*WORD_BITS +: WORD_BITS] = shift_q[j][FRAME_BITS-1 -: WORD_BITS];
        shift_d[j] = shift_q[j] << WORD_BITS;
      end
    end
  end

  always_ff @(posedge sysclk_i) begin
    if (rst_i) begin
      beat_cnt_q    <= '0;
      shift_q       <= '0;
      lane_data_q   <= '0;
      frame_start_q <= 1'b0;
      in_train_q    <= 1'b1;
    end else begin
      beat_cnt_q    <= beat_cnt_d;
      shift_q       <= shift_d;
      lane_data_q   <= lane_data_d;
      frame_start_q <= frame_start_d;
      in_train_q    <= in_train_d;
    end
  end

  assign lane_data_o   = lane_data_q;
  assign frame_start_o = frame_start_q;
  assign in_train_o    = in_train_q;

endmodule

// File: tb/tb_turf_cout_framer.sv
// Scoreboard bench for turf_cout_framer: default 7+1 lane instance and a
// 3+1 lane, 8-bit, 4-beat instance driven from directed frame vectors.
module tb_turf_cout_framer;

  localparam int NS_A = 7, L_A = 8, WB_A = 4, FB_A = 8;
  localparam int NS_B = 3, L_B = 4, WB_B = 8, FB_B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_a, train_a, sync_a, valid_a, ready_a, fs_a, it_a;
  logic [31:0]         resp_a;
  logic [NS_A*32-1:0]  surf_a;
  logic [L_A-1:0]      en_a;
  logic [L_A*WB_A-1:0] data_a;

  logic                rst_b, train_b, sync_b, valid_b, ready_b, fs_b, it_b;
  logic [31:0]         resp_b;
  logic [NS_B*32-1:0]  surf_b;
  logic [L_B-1:0]      en_b;
  logic [L_B*WB_B-1:0] data_b;

  turf_cout_framer dut_a (
    .sysclk_i(clk), .rst_i(rst_a), .train_i(train_a), .sync_i(sync_a),
    .response_i(resp_a), .surf_response_i(surf_a), .resp_valid_i(valid_a),
    .resp_ready_o(ready_a), .lane_enable_i(en_a), .lane_data_o(data_a),
    .frame_start_o(fs_a), .in_train_o(it_a)
  );

  turf_cout_framer #(.NUM_SURF(NS_B), .WORD_BITS(WB_B), .FRAME_BEATS(FB_B),
                     .TRAIN_PATTERN(32'hA55A6996), .IDLE_WORD(32'h0)) dut_b (
    .sysclk_i(clk), .rst_i(rst_b), .train_i(train_b), .sync_i(sync_b),
    .response_i(resp_b), .surf_response_i(surf_b), .resp_valid_i(valid_b),
    .resp_ready_o(ready_b), .lane_enable_i(en_b), .lane_data_o(data_b),
    .frame_start_o(fs_b), .in_train_o(it_b)
  );

  typedef struct {
    logic [7:0][31:0] w;
    logic             tr;
    int               nb;
  } frame_t;

  frame_t q_a[$], q_b[$];
  int errors = 0;
  int checks = 0;
  bit mon_a = 1'b0, mon_b = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] beat_a(input frame_t f, input int b);
    logic [31:0] e = '0;
    for (int j = 0; j < L_A; j++) e[j*WB_A +: WB_A] = f.w[j][31 - b*WB_A -: WB_A];
    return e;
  endfunction

  function automatic logic [31:0] beat_b(input frame_t f, input int b);
    logic [31:0] e = '0;
    for (int j = 0; j < L_B; j++) e[j*WB_B +: WB_B] = f.w[j][31 - b*WB_B -: WB_B];
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called in a load cycle: drives train/valid, checks the handshake and queues the frame.
  task automatic applyStimulus(input bit inst, input logic tr, input logic va,
                               input logic exp_ready, input int nb);
    frame_t f;
    logic [31:0] word;
    f.w  = '0;
    f.tr = tr;
    f.nb = nb;
    if (!inst) begin
      train_a = tr;
      valid_a = va;
      #1;
      checkOutput("A resp_ready at load", ready_a, exp_ready);
      for (int j = 0; j < L_A; j++) begin
        if (j < NS_A) word = surf_a[j*32 +: 32];
        else          word = resp_a;
        f.w[j] = tr ? 32'hA55A6996 : (va && en_a[j]) ? word : 32'h0;
      end
      q_a.push_back(f);
    end else begin
      train_b = tr;
      valid_b = va;
      #1;
      checkOutput("B resp_ready at load", ready_b, exp_ready);
      for (int j = 0; j < L_B; j++) begin
        if (j < NS_B) word = surf_b[j*32 +: 32];
        else          word = resp_b;
        f.w[j] = tr ? 32'hA55A6996 : (va && en_b[j]) ? word : 32'h0;
      end
      q_b.push_back(f);
    end
    @(posedge clk);
    #1;
  endtask

  frame_t cur_a, cur_b;
  int     b_a = 0, b_b = 0;
  bit     act_a = 1'b0, act_b = 1'b0;

  always @(negedge clk) begin
    if (mon_a) begin
      if (!act_a || (b_a + 1 >= cur_a.nb)) begin
        if (act_a) checkOutput("A frame_start at frame end", fs_a, 1'b1);
        if (fs_a) begin
          if (q_a.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL A frame_start: got unexpected frame, required none queued");
            act_a = 1'b0;
          end else begin
            cur_a = q_a.pop_front();
            b_a   = 0;
            act_a = 1'b1;
            checkOutput("A in_train", it_a, cur_a.tr);
            checkOutput("A lane_data beat 0", data_a, beat_a(cur_a, 0));
          end
        end else begin
          act_a = 1'b0;
        end
      end else begin
        b_a++;
        checkOutput("A frame_start mid-frame", fs_a, 1'b0);
        checkOutput($sformatf("A lane_data beat %0d", b_a), data_a, beat_a(cur_a, b_a));
      end
    end
  end

  always @(negedge clk) begin
    if (mon_b) begin
      if (!act_b || (b_b + 1 >= cur_b.nb)) begin
        if (act_b) checkOutput("B frame_start at frame end", fs_b, 1'b1);
        if (fs_b) begin
          if (q_b.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL B frame_start: got unexpected frame, required none queued");
            act_b = 1'b0;
          end else begin
            cur_b = q_b.pop_front();
            b_b   = 0;
            act_b = 1'b1;
            checkOutput("B in_train", it_b, cur_b.tr);
            checkOutput("B lane_data beat 0", data_b, beat_b(cur_b, 0));
          end
        end else begin
          act_b = 1'b0;
        end
      end else begin
        b_b++;
        checkOutput("B frame_start mid-frame", fs_b, 1'b0);
        checkOutput($sformatf("B lane_data beat %0d", b_b), data_b, beat_b(cur_b, b_b));
      end
    end
  end

  initial begin
    rst_a = 1'b1; train_a = 1'b0; sync_a = 1'b0; valid_a = 1'b1;
    resp_a = 32'h12345678; en_a = '1;
    surf_a = {32'h77777777, 32'h66666666, 32'h55555555, 32'hDEADBEEF,
              32'h33333333, 32'h22222222, 32'h11111111};
    rst_b = 1'b1; train_b = 1'b0; sync_b = 1'b0; valid_b = 1'b1;
    resp_b = 32'h11223344; en_b = '1;
    surf_b = {32'hF0E0D0C0, 32'h01020304, 32'hAABBCCDD};

    tick(3);
    checkOutput("A reset lane_data", data_a, 32'h0);
    checkOutput("A reset frame_start", fs_a, 1'b0);
    checkOutput("A reset in_train", it_a, 1'b1);
    checkOutput("A reset resp_ready", ready_a, 1'b0);

    // Instance A: training, data, enables, idle, late valid, sync truncation, sync held.
    rst_a = 1'b0;
    mon_a = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 1'b0, FB_A);
    tick(FB_A - 1);
    applyStimulus(0, 1'b1, 1'b1, 1'b0, FB_A);
    tick(FB_A - 1);

    applyStimulus(0, 1'b0, 1'b1, 1'b1, FB_A);
    checkOutput("A resp_ready mid-frame", ready_a, 1'b0);
    en_a = '0; resp_a = 32'hFFFFFFFF; train_a = 1'b1;
    tick(FB_A - 2);
    en_a = 8'b0111_1110; resp_a = 32'h12345678; train_a = 1'b0;
    tick(1);

    applyStimulus(0, 1'b0, 1'b1, 1'b1, FB_A);
    en_a = '1;
    tick(FB_A - 1);

    applyStimulus(0, 1'b0, 1'b0, 1'b0, FB_A);
    tick(2);
    valid_a = 1'b1;
    #1;
    checkOutput("A late valid not accepted", ready_a, 1'b0);
    tick(FB_A - 3);

    resp_a = 32'hCAFEF00D;
    applyStimulus(0, 1'b0, 1'b1, 1'b1, 5);
    tick(3);
    sync_a = 1'b1;
    tick(1);
    sync_a = 1'b0;
    resp_a = 32'h0BADC0DE;
    applyStimulus(0, 1'b0, 1'b1, 1'b1, FB_A);
    tick(FB_A - 1);

    sync_a = 1'b1;
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 1);
    applyStimulus(0, 1'b0, 1'b1, 1'b1, 1);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 1);
    sync_a = 1'b0;
    applyStimulus(0, 1'b0, 1'b1, 1'b1, FB_A);
    tick(FB_A - 1);
    @(posedge clk);
    mon_a = 1'b0;
    checkOutput("A frames left in queue", q_a.size(), 0);

    // Instance B: 8-bit words, 4-beat frames.
    #1;
    checkOutput("B reset lane_data", data_b, 32'h0);
    checkOutput("B reset in_train", it_b, 1'b1);
    rst_b = 1'b0;
    mon_b = 1'b1;
    applyStimulus(1, 1'b0, 1'b1, 1'b1, FB_B);
    tick(FB_B - 1);
    applyStimulus(1, 1'b1, 1'b1, 1'b0, FB_B);
    tick(FB_B - 1);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, FB_B);
    tick(FB_B - 1);
    @(posedge clk);
    mon_b = 1'b0;
    checkOutput("B frames left in queue", q_b.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
